// File: rtl/dx_issue_ctrl.sv
// dx_issue_ctrl: decode->execute issue controller.
// Owns the decode/X-stage valid/ready handshake, tracks in-flight writes in a
// register scoreboard, drains around serializing instructions and squashes
// decode on a taken redirect.
// Optional feature macro: DX_ISSUE_WB_BYPASS_EN (same-cycle writeback bypass
// into the hazard check and the in-flight slot check).
module dx_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_valid,
  output logic       d_ready,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic       d_rs1_used,
  input  logic       d_rs2_used,
  input  logic [4:0] d_rd,
  input  logic       d_wen,
  input  logic       d_serial,
  output logic       x_valid,
  input  logic       x_ready,
  input  logic       wb_valid,
  input  logic       wb_wen,
  input  logic [4:0] wb_rd,
  input  logic       redirect,
  output logic       flush_d,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_inflight;
  logic [31:0]     r_pend;     // bit 0 is kept at zero: x0 is never pending
  logic            r_err;

  logic [31:0]     w_clr_vec;
  logic [31:0]     w_set_vec;
  logic [31:0]     w_pend_eff;
  logic            w_full;
  logic            w_cnt_zero;
  logic            w_hazard;
  logic            w_issue_ok;
  logic            w_fire;
  logic            w_ret;
  logic            w_stray;

  assign w_cnt_zero = (r_inflight == {CW{1'b0}});

  // Scoreboard bits cleared by this cycle's writeback (x0 masked out).
  assign w_clr_vec = (wb_valid & wb_wen) ? ((32'd1 << wb_rd) & ~32'd1) : 32'd0;

`ifdef DX_ISSUE_WB_BYPASS_EN
  // A retiring write is already visible to the consumer, and its slot is free.
  assign w_pend_eff = r_pend & ~w_clr_vec;
  assign w_full     = (r_inflight == MAX_CNT) & ~wb_valid;
`else
  assign w_pend_eff = r_pend;
  assign w_full     = (r_inflight == MAX_CNT);
`endif

  assign w_hazard = (d_rs1_used & w_pend_eff[d_rs1]) |
                    (d_rs2_used & w_pend_eff[d_rs2]) |
                    (d_wen      & w_pend_eff[d_rd])  |
                    w_full;

  // A serializing instruction may only issue into an empty pipeline.
  assign w_issue_ok = rst & (r_state == ST_RUN) & ~w_hazard & ~redirect &
                      ~(d_serial & ~w_cnt_zero);

  assign x_valid = d_valid & w_issue_ok;
  assign d_ready = x_ready & w_issue_ok;
  assign w_fire  = x_valid & x_ready;
  assign flush_d = rst & redirect;
  assign busy    = rst & ~w_cnt_zero;
  assign err     = r_err;

  assign w_set_vec = (w_fire & d_wen) ? ((32'd1 << d_rd) & ~32'd1) : 32'd0;
  assign w_ret     = wb_valid & ~w_cnt_zero;
  assign w_stray   = wb_valid & w_cnt_zero;

  // In-flight counter, scoreboard and sticky retire-underflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inflight <= {CW{1'b0}};
      r_pend     <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case ({w_fire, w_ret})
        2'b10:   r_inflight <= r_inflight + ONE_CNT;
        2'b01:   r_inflight <= r_inflight - ONE_CNT;
        default: r_inflight <= r_inflight;
      endcase
      // Clear first, then set: a same-register set/clear leaves it pending.
      r_pend <= (r_pend & ~w_clr_vec) | w_set_vec;
      r_err  <= r_err | w_stray;
    end
  end

  // Issue sequencing: drain before serials, hold while a serial is alone
  // in flight, one bubble after a redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else if (redirect) begin
      r_state <= ST_FLUSH;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_fire & d_serial) begin
            r_state <= ST_SERIAL;
          end else if (d_valid & d_serial & ~w_cnt_zero) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_DRAIN, ST_SERIAL: begin
          if (w_cnt_zero) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= r_state;
          end
        end
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dx_issue_ctrl.sv
// Testbench for dx_issue_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural model that keeps an
// in-order queue of issued instructions, a pending-register set and a
// "blocked until empty" / "one bubble" pair of flags.
module tb_dx_issue_ctrl;

  localparam int MAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_valid, d_ready;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic       d_rs1_used, d_rs2_used, d_wen, d_serial;
  logic       x_valid, x_ready;
  logic       wb_valid, wb_wen;
  logic [4:0] wb_rd;
  logic       redirect, flush_d, busy, err;

  dx_issue_ctrl #(.MAX_INFLIGHT(MAX)) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .d_rd(d_rd), .d_wen(d_wen), .d_serial(d_serial),
    .x_valid(x_valid), .x_ready(x_ready),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .redirect(redirect), .flush_d(flush_d), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { bit wen; logic [4:0] rd; } ent_t;

  int         n_checks = 0;
  int         n_err    = 0;
  int         m_cnt;
  bit  [31:0] m_pend;
  bit         m_err, m_flush, m_block;
  ent_t       m_q[$];
  logic       last_xv, last_fl, last_err;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic instr(input bit v, input bit s, input bit u1, input logic [4:0] r1,
                       input bit u2, input logic [4:0] r2, input bit w, input logic [4:0] rd);
    d_valid = v; d_serial = s; d_rs1_used = u1; d_rs1 = r1;
    d_rs2_used = u2; d_rs2 = r2; d_wen = w; d_rd = rd;
  endtask

  // Retire the oldest in-flight instruction; with nothing in flight this is a stray retire.
  task automatic wb(input bit v);
    if (v && m_q.size() > 0) begin
      wb_valid = 1'b1; wb_wen = m_q[0].wen; wb_rd = m_q[0].rd;
    end else if (v) begin
      wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd9;
    end else begin
      wb_valid = 1'b0; wb_wen = 1'b0; wb_rd = 5'd0;
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic step();
    bit [31:0] pe;
    bit full, hz, ok, e_xv, e_dr, e_fl, e_busy, fire;
    int old;
    #2;
    if (!rst) begin
      e_xv = 1'b0; e_dr = 1'b0; e_fl = 1'b0; e_busy = 1'b0;
    end else begin
      pe = m_pend;
`ifdef DX_ISSUE_WB_BYPASS_EN
      if (wb_valid && wb_wen) pe[wb_rd] = 1'b0;
      full = (m_cnt - (wb_valid ? 1 : 0)) >= MAX;
`else
      full = m_cnt >= MAX;
`endif
      pe[0] = 1'b0;
      hz = (d_rs1_used && pe[d_rs1]) || (d_rs2_used && pe[d_rs2]) ||
           (d_wen && pe[d_rd]) || full;
      ok = !m_flush && !m_block && !hz && !redirect && !(d_serial && m_cnt != 0);
      e_xv = d_valid && ok;
      e_dr = x_ready && ok;
      e_fl = redirect;
      e_busy = (m_cnt != 0);
    end
    chk("x_valid", x_valid, e_xv);
    chk("d_ready", d_ready, e_dr);
    chk("flush_d", flush_d, e_fl);
    chk("busy",    busy,    e_busy);
    chk("err",     err,     m_err);
    last_xv = x_valid; last_fl = flush_d; last_err = err;
    @(posedge clk);
    if (!rst) begin
      m_cnt = 0; m_pend = 32'd0; m_err = 1'b0; m_flush = 1'b0; m_block = 1'b0;
      m_q.delete();
    end else begin
      fire = e_xv && x_ready;
      old  = m_cnt;
      if (wb_valid) begin
        if (old == 0) m_err = 1'b1;
        else m_cnt--;
        if (m_q.size() > 0) void'(m_q.pop_front());
        if (wb_wen && wb_rd != 5'd0) m_pend[wb_rd] = 1'b0;
      end
      if (fire) begin
        m_cnt++;
        if (d_wen && d_rd != 5'd0) m_pend[d_rd] = 1'b1;
        m_q.push_back('{d_wen, d_rd});
      end
      if (redirect) begin
        m_flush = 1'b1; m_block = 1'b0;
      end else if (m_flush) begin
        m_flush = 1'b0;
      end else if (m_block) begin
        if (old == 0) m_block = 1'b0;
      end else if ((fire && d_serial) || (d_valid && d_serial && old != 0)) begin
        m_block = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic retire_all();
    instr(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    for (int k = 0; k < 20 && m_q.size() > 0; k++) begin
      wb(1); step();
    end
    wb(0); step();
  endtask

  initial begin
    rst = 1'b0; x_ready = 1'b1; redirect = 1'b0;
    instr(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0); wb(0);
    m_cnt = 0; m_pend = 32'd0; m_err = 1'b0; m_flush = 1'b0; m_block = 1'b0;
    @(negedge clk);
    step(); step();
    rst = 1'b1;
    step();

    // Fill to MAX_INFLIGHT with independent writes, then stall until a retire.
    for (int i = 0; i < MAX; i++) begin
      instr(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'(10 + i)); step();
      chk("fill_issue", last_xv, 1'b1);
    end
    instr(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd14); step();
    chk("fill_full_stall", last_xv, 1'b0);
    wb(1); step();
`ifdef DX_ISSUE_WB_BYPASS_EN
    chk("fill_wb_same_cycle", last_xv, 1'b1);
`else
    chk("fill_wb_same_cycle", last_xv, 1'b0);
    wb(0); step();
    chk("fill_wb_next_cycle", last_xv, 1'b1);
`endif
    retire_all();

    // RAW on x5.
    instr(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd5); step();
    chk("raw_producer", last_xv, 1'b1);
    instr(1, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0); step();
    chk("raw_stall0", last_xv, 1'b0);
    step();
    chk("raw_stall1", last_xv, 1'b0);
    wb(1); step();
`ifdef DX_ISSUE_WB_BYPASS_EN
    chk("raw_wb_cycle", last_xv, 1'b1);
    wb(0);
`else
    chk("raw_wb_cycle", last_xv, 1'b0);
    wb(0); step();
    chk("raw_after_wb", last_xv, 1'b1);
`endif
    retire_all();

    // Serial instruction arriving with two in flight.
    instr(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd6); step();
    instr(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd7); step();
    instr(1, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0); step();
    chk("serial_drain_enter", last_xv, 1'b0);
    wb(1); step(); chk("serial_drain_wb1", last_xv, 1'b0);
    wb(1); step(); chk("serial_drain_wb2", last_xv, 1'b0);
    wb(0); step(); chk("serial_drain_last", last_xv, 1'b0);
    step();        chk("serial_issue", last_xv, 1'b1);
    instr(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd8);
    step();        chk("serial_alone0", last_xv, 1'b0);
    wb(1); step(); chk("serial_alone_wb", last_xv, 1'b0);
    wb(0); step(); chk("serial_alone_back", last_xv, 1'b0);
    step();        chk("serial_follow_issue", last_xv, 1'b1);
    retire_all();

    // Redirect while decode is valid.
    instr(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd9); redirect = 1'b1; step();
    chk("redir_xv", last_xv, 1'b0);
    chk("redir_flush", last_fl, 1'b1);
    redirect = 1'b0; step();
    chk("redir_bubble", last_xv, 1'b0);
    step();
    chk("redir_resume", last_xv, 1'b1);
    retire_all();

    // x0 never pending, never a hazard.
    instr(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd0); step();
    chk("x0_write", last_xv, 1'b1);
    instr(1, 0, 1, 5'd0, 1, 5'd0, 1, 5'd0); step();
    chk("x0_read", last_xv, 1'b1);
    retire_all();

    // Reset with three in flight and pending registers.
    for (int i = 1; i <= 3; i++) begin
      instr(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'(i)); step();
    end
    rst = 1'b0; instr(1, 0, 1, 5'd1, 0, 5'd0, 1, 5'd2); step();
    chk("rst_xv", last_xv, 1'b0);
    rst = 1'b1; step();
    chk("post_rst_issue", last_xv, 1'b1);
    retire_all();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      instr(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)));
      x_ready  = 1'($urandom_range(0, 3) != 0);
      redirect = 1'($urandom_range(0, 19) == 0);
      wb((m_q.size() > 0) && ($urandom_range(0, 1) == 1));
      step();
    end
    redirect = 1'b0; x_ready = 1'b1;
    retire_all();

    // Stray retire sets a sticky error, cleared only by reset.
    wb(1); step();
    wb(0); step();
    chk("err_set", last_err, 1'b1);
    step(); step();
    chk("err_sticky", last_err, 1'b1);
    rst = 1'b0; step();
    rst = 1'b1; step();
    chk("err_cleared", last_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dx_issue_ctrl.md
# dx_issue_ctrl

Issue controller that sequences the decode→execute stage register. It owns the valid/ready handshake between decode and the D→X stage register, and stalls on RAW/WAW hazards using a register scoreboard. It drains the pipeline around serializing instructions (ecall/mret/CSR) and squashes decode on a taken redirect. It sits between the decode stage outputs and the `s_valid`/`s_ready` side of the X stage register; writeback feedback closes the loop.

## Interface
- `MAX_INFLIGHT`, default 4: maximum number of issued, not-yet-retired instructions; range 1..15.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-low.
- `d_valid` in 1: decode presents an instruction.
- `d_ready` out 1: decode instruction accepted this cycle.
- `d_rs1`, `d_rs2` in 5 each: source register indices.
- `d_rs1_used`, `d_rs2_used` in 1 each: the corresponding source is read.
- `d_rd` in 5: destination register index.
- `d_wen` in 1: the instruction writes `d_rd`.
- `d_serial` in 1: serializing instruction (ecall, mret, CSR access).
- `x_valid` out 1: drives the stage register `s_valid`.
- `x_ready` in 1: from the stage register `s_ready`.
- `wb_valid` in 1: one instruction retires this cycle.
- `wb_wen` in 1: the retiring instruction wrote `wb_rd`.
- `wb_rd` in 5: retiring destination register.
- `redirect` in 1: taken branch/jump/trap resolved in X this cycle.
- `flush_d` out 1: squash the instruction currently in decode.
- `busy` out 1: in-flight count is non-zero.
- `err` out 1: sticky; set on retire with an in-flight count of 0.

## Operation
- State registers:
  - `state` ∈ {RUN, DRAIN, SERIAL, FLUSH}.
  - `inflight` counter, width $clog2(MAX_INFLIGHT+1).
  - `pend[31:1]` scoreboard; x0 is never pending.
- Hazard when any of the following holds:
  - `d_rs1_used` and `pend[d_rs1]`.
  - `d_rs2_used` and `pend[d_rs2]`.
  - `d_wen` and `pend[d_rd]` (WAW).
  - `inflight==MAX_INFLIGHT`.
  - Register index 0 never hazards.
- Issue condition:
  - `issue_ok = (state==RUN) & ~hazard & ~redirect & ~(d_serial & inflight!=0)`.
  - `x_valid = d_valid & issue_ok`.
  - `d_ready = x_ready & issue_ok`.
  - Issue fires on `x_valid & x_ready`.
- On issue:
  - `inflight` increments.
  - If `d_wen & d_rd!=0`, `pend[d_rd]` is set.
- On `wb_valid`:
  - `inflight` decrements; if it is 0, the counter holds and `err` sets.
  - If `wb_wen & wb_rd!=0`, `pend[wb_rd]` is cleared.
- Simultaneous issue and retire: the count is unchanged. If both target the same register, set wins.
- State transitions, RUN:
  - `d_valid & d_serial & inflight!=0` → DRAIN.
  - Serial instruction issues → SERIAL.
- State transitions, DRAIN: when `inflight==0` (registered) → RUN. No issue while in DRAIN.
- State transitions, SERIAL: when `inflight==0` → RUN. No issue while in SERIAL, so the serial instruction retires alone.
- State transitions, FLUSH: one cycle, no issue, then → RUN.
- `redirect` from any state:
  - `flush_d=1` combinationally and issue is blocked that cycle.
  - Next state is FLUSH.
  - Scoreboard and counter are unaffected; the redirecting instruction still retires normally.
- `busy = inflight!=0`.

## Timing
- Reset (`rst==0` at a clock edge):
  - `state`=RUN, `inflight`=0, `pend`=0, `err`=0.
  - `x_valid`, `d_ready`, `flush_d` and `busy` are forced to 0 while `rst` is low.
- Reset mid-operation discards all in-flight tracking. Stray `wb_valid` after reset sets `err`.
- Zero-cycle issue latency: the handshake is combinational from `d_valid`, `x_ready` and registered state.
- The hazard check uses registered `pend`. Without bypass, a consumer issues no earlier than the cycle after its producer's `wb_valid`.
- Serial instruction minimum cost:
  - Drain cycles until `inflight==0` (registered).
  - Issue cycle.
  - Retire, plus one cycle back to RUN.
- Redirect costs one bubble (the FLUSH cycle) after the redirect cycle.
- `err` holds until reset.

## Configuration
- `DX_ISSUE_WB_BYPASS_EN`:
  - Defined: a register being cleared by `wb_valid & wb_wen` this cycle is treated as not pending, and a retire this cycle frees one slot for the MAX_INFLIGHT check. A dependent instruction issues in the same cycle as its producer's writeback, and set/clear on the same register can coincide (set wins).
  - Undefined: hazard checks use registered state only.

## Test plan
- Reset, then hold `d_valid=1` with independent instructions and `x_ready=1`. Expect issue every cycle until `inflight==4`, then `x_valid=0` with no wb. One `wb_valid` gives issue again the next cycle.
- Issue rd=5. Next instruction has rs1=5 and `d_rs1_used=1`: expect a stall. With `wb_valid`, `wb_wen`, `wb_rd=5` at cycle N, expect issue at N+1 (no macro) or at N (macro defined).
- Serial instruction arrives with `inflight=2`:
  - Expect DRAIN, with no issue for 2 retire cycles.
  - Then issue with `inflight` 0→1 and state SERIAL.
  - A following instruction waits until the serial instruction retires.
- `redirect=1` while `d_valid=1`: expect `flush_d=1` and `x_valid=0` that cycle, `x_valid=0` the next cycle (FLUSH), then issue resumes.
- Edge cases:
  - rd=0 with `d_wen=1` sets no pend.
  - rs1=0 never stalls.
  - `wb_valid` with `inflight=0` sets `err`, which stays 1 until `rst=0`.
- Assert `rst=0` for one cycle with `inflight=3` and pend bits set: all outputs 0, then the next instruction issues immediately.
